hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the IF/ID register, the PC and the ID/EX register.
//  Detects RAW hazards between the instruction in ID and the writers in EX and MEM; there is no forwarding.
//  Stalls PC and IF/ID and injects ID/EX bubbles until the producer reaches writeback.
//  Flushes wrong-path instructions on a taken branch. Honours a global external freeze.
// PARAMETERS
//  REG_AW        6  register-index width
//  FLUSH_CYCLES  2  cycles of IF/ID flush after a taken branch (1..7)
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous, active-high reset
//  id_rs        in   REG_AW  source A index of the instruction in ID
//  id_rt        in   REG_AW  source B index of the instruction in ID
//  id_use_rs    in   1       ID instruction reads rs
//  id_use_rt    in   1       ID instruction reads rt
//  ex_rd        in   REG_AW  destination index in EX
//  ex_wr        in   1       EX instruction writes ex_rd
//  mem_rd       in   REG_AW  destination index in MEM
//  mem_wr       in   1       MEM instruction writes mem_rd
//  br_taken     in   1       taken branch resolved this cycle
//  ext_stall    in   1       global freeze (memory wait)
//  pc_en        out  1       PC load enable
//  ifid_en      out  1       IF/ID load enable
//  ifid_flush   out  1       IF/ID load NOP (overrides ifid_en)
//  idex_bubble  out  1       ID/EX load NOP
//  busy         out  1       state != RUN
//  stall_cnt    out  32      stall-cycle count (see CONFIGURATION)
//  flush_cnt    out  32      flush-cycle count (see CONFIGURATION)
// BEHAVIOUR
//  - Registers: state {RUN, STALL, FLUSH}, cnt[2:0]. Outputs decode combinationally (Mealy) from state and inputs.
//  - While rst=1: state=RUN, cnt=0, pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1, busy=0, counters=0.
//  - ex_hit  = ex_wr  & ((id_use_rs & id_rs==ex_rd)  | (id_use_rt & id_rt==ex_rd)).
//  - mem_hit = mem_wr & ((id_use_rs & id_rs==mem_rd) | (id_use_rt & id_rt==mem_rd)). Register 0 is not special.
//  - Priority per cycle: ext_stall > br_taken > FLUSH > STALL > hazard > normal.
//  - ext_stall=1: pc_en=0, ifid_en=0, ifid_flush=0, idex_bubble=0. State, cnt and counters hold.
//    Upstream holds br_taken stable while frozen.
//  - Normal (RUN, no hit): pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0.
//  - Hazard in RUN (stall cycle 1): pc_en=0, ifid_en=0, idex_bubble=1.
//    - ex_hit: next state=STALL, cnt=1 (2 stall cycles total).
//    - mem_hit only: stay in RUN (1 stall cycle); hazard is re-evaluated next cycle.
//  - STALL: outputs as hazard. cnt==1 -> RUN next cycle; otherwise cnt-1.
//  - br_taken in any state: pc_en=1, ifid_en=1, ifid_flush=1, idex_bubble=1.
//    Any pending STALL is cancelled.
//    If FLUSH_CYCLES>1: next state=FLUSH, cnt=FLUSH_CYCLES-1; else next state=RUN.
//  - FLUSH: pc_en=1, ifid_flush=1, idex_bubble=1. cnt==1 -> RUN; else cnt-1.
//    br_taken during FLUSH reloads cnt=FLUSH_CYCLES-1.
//  - Hazards are ignored in FLUSH because the ID instruction is a NOP.
//  - Reset asserted mid-STALL or mid-FLUSH aborts immediately to reset values.
// CONFIGURATION
//  - HAZ_STATS_EN defined:
//    - stall_cnt += 1 on every non-frozen cycle with idex_bubble=1 and ifid_flush=0.
//    - flush_cnt += 1 on every non-frozen cycle with ifid_flush=1.
//    - Both are 32-bit, wrap at 2^32, and clear on rst.
//  - HAZ_STATS_EN undefined: stall_cnt and flush_cnt are tied to 0; ports remain present.
// TESTING
//  - rst=1 for 3 cycles, then release with no hits
//    -> pc_en=ifid_en=1, flush=bubble=0 from the first post-reset cycle; while rst=1, pc_en=0 and ifid_flush=1.
//  - ex_wr=1, ex_rd=5, id_rs=5, id_use_rs=1; MEM then carries rd=5 with the bubble
//    -> exactly 2 cycles with pc_en=0, idex_bubble=1, then RUN; stall_cnt=2.
//  - mem_wr=1, mem_rd=9, id_rt=9, id_use_rt=1, ex_wr=0
//    -> exactly 1 stall cycle; busy stays 0.
//  - Hazard on rd=3 from EX (STALL, cnt=1), br_taken=1 the next cycle
//    -> stall cancelled; ifid_flush=1 for 2 cycles (FLUSH_CYCLES=2); flush_cnt=2.
//  - ext_stall=1 for 4 cycles in mid-STALL
//    -> all enables and bubbles 0 for 4 cycles; afterwards the remaining stall cycle completes.
//  - id_use_rs=0, id_rs=ex_rd=7, ex_wr=1
//    -> no stall; and with ex_wr=0 and a matching index -> no stall.

Source files
------------

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline sequencer for the PC, the IF/ID register and the ID/EX register.
//   Detects RAW hazards between the instruction in ID and the EX / MEM
//   writers (no forwarding). It stalls PC and IF/ID and injects ID/EX bubbles
//   until the producer reaches writeback. It flushes wrong-path instructions
//   after a taken branch, and it honours a global external freeze.
//
//   Optional feature macro: HAZ_STATS_EN
//     defined   -> stall_cnt / flush_cnt are live 32-bit wrapping counters
//     undefined -> stall_cnt / flush_cnt are tied to zero
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   id_rs, id_rt       source indices of the instruction in ID
//   id_use_rs/rt       the ID instruction reads rs / rt
//   ex_rd, ex_wr       destination index and write flag of the EX instruction
//   mem_rd, mem_wr     destination index and write flag of the MEM instruction
//   br_taken           a taken branch is resolved this cycle
//   ext_stall          global freeze (memory wait)
//   pc_en              PC load enable
//   ifid_en            IF/ID load enable
//   ifid_flush         IF/ID loads a NOP (overrides ifid_en)
//   idex_bubble        ID/EX loads a NOP
//   busy               sequencer is in STALL or FLUSH
//   stall_cnt          bubble-only cycle count (HAZ_STATS_EN)
//   flush_cnt          flush cycle count (HAZ_STATS_EN)
//
//   The control outputs are Mealy: they decode combinationally from the
//   state and the current inputs, because the pipeline acts on them in the
//   same cycle.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int unsigned REG_AW       = 6,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_wr,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_wr,
    input  logic              br_taken,
    input  logic              ext_stall,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              busy,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
);

    localparam int unsigned CNT_W        = 3;
    localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic FLUSH_MULTI  = (FLUSH_CYCLES > 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic ex_hit;
    logic mem_hit;

    // RAW hazard detection; register 0 is an ordinary register here.
    assign ex_hit  = ex_wr  & ((id_use_rs & (id_rs == ex_rd))
                            |  (id_use_rt & (id_rt == ex_rd)));
    assign mem_hit = mem_wr & ((id_use_rs & (id_rs == mem_rd))
                            |  (id_use_rt & (id_rt == mem_rd)));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and Mealy output decode.
    // Priority: ext_stall > br_taken > FLUSH > STALL > hazard > normal.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        busy        = (state_q != ST_RUN);

        if (rst) begin
            // Reset holds the pipeline with NOPs in both registers.
            state_d     = ST_RUN;
            cnt_d       = '0;
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            busy        = 1'b0;
        end else if (ext_stall) begin
            // Freeze: nothing moves, state and counters hold.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
        end else if (br_taken) begin
            // Redirect: load the target, kill the wrong path, drop any stall.
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            if (FLUSH_MULTI) begin
                state_d = ST_FLUSH;
                cnt_d   = FLUSH_RELOAD;
            end else begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        end else begin
            unique case (state_q)
                ST_FLUSH: begin
                    // ID holds a NOP, so hazards are not evaluated here.
                    pc_en       = 1'b1;
                    ifid_en     = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q - CNT_W'(1);
                    end
                end
                ST_STALL: begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    if (ex_hit || mem_hit) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_bubble = 1'b1;
                        // An EX producer needs one more cycle to reach WB;
                        // a MEM producer is re-evaluated next cycle instead.
                        if (ex_hit) begin
                            state_d = ST_STALL;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

`ifdef HAZ_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Statistics: bubble-only cycles and flush cycles, frozen cycles excluded.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!ext_stall) begin
            if (idex_bubble && !ifid_flush) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
            if (ifid_flush) begin
                flush_cnt_d = flush_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed scenarios followed by randomized traffic, each cycle checked
//   against a behavioural model built from "cycles remaining" counts.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int AW = 6;
    localparam int FC = 2;

    logic          clk;
    logic          rst;
    logic [AW-1:0] id_rs, id_rt, ex_rd, mem_rd;
    logic          id_use_rs, id_use_rt, ex_wr, mem_wr, br_taken, ext_stall;
    logic          pc_en, ifid_en, ifid_flush, idex_bubble, busy;
    logic [31:0]   stall_cnt, flush_cnt;

    hazard_ctrl #(.REG_AW(AW), .FLUSH_CYCLES(FC)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_use_rs  (id_use_rs),
        .id_use_rt  (id_use_rt),
        .ex_rd      (ex_rd),
        .ex_wr      (ex_wr),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .br_taken   (br_taken),
        .ext_stall  (ext_stall),
        .pc_en      (pc_en),
        .ifid_en    (ifid_en),
        .ifid_flush (ifid_flush),
        .idex_bubble(idex_bubble),
        .busy       (busy),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Model: cycles still owed to a stall or a flush, plus statistics.
    int          stall_rem = 0;
    int          flush_rem = 0;
    logic [31:0] m_stall_cnt = 0;
    logic [31:0] m_flush_cnt = 0;

    // Last observed outputs, for scenario-level counting.
    logic        obs_pc_en, obs_flush;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic set_in(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                          input logic urs, input logic urt,
                          input logic [AW-1:0] erd, input logic ewr,
                          input logic [AW-1:0] mrd, input logic mwr,
                          input logic br, input logic ext);
        id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        ex_rd = erd; ex_wr = ewr; mem_rd = mrd; mem_wr = mwr;
        br_taken = br; ext_stall = ext;
    endtask

    // One cycle: inputs already applied after negedge; check, then advance.
    task automatic cyc();
        logic e_pc, e_en, e_fl, e_bub, e_busy, chk_en;
        logic ex_h, mem_h;
        int   n_stall, n_flush;
        #1;
        ex_h  = ex_wr  && ((id_use_rs && id_rs == ex_rd)  || (id_use_rt && id_rt == ex_rd));
        mem_h = mem_wr && ((id_use_rs && id_rs == mem_rd) || (id_use_rt && id_rt == mem_rd));
        n_stall = stall_rem;
        n_flush = flush_rem;
        chk_en  = 1'b1;
        e_busy  = (stall_rem > 0) || (flush_rem > 0);
        if (rst) begin
            {e_pc, e_en, e_fl, e_bub} = 4'b0011;
            e_busy = 1'b0;
            n_stall = 0; n_flush = 0;
            stall_rem = 0; flush_rem = 0;
            m_stall_cnt = 0; m_flush_cnt = 0;
        end else if (ext_stall) begin
            {e_pc, e_en, e_fl, e_bub} = 4'b0000;
        end else if (br_taken) begin
            {e_pc, e_en, e_fl, e_bub} = 4'b1111;
            n_stall = 0;
            n_flush = FC - 1;
        end else if (flush_rem > 0) begin
            {e_pc, e_fl, e_bub} = 3'b111;
            e_en   = 1'b0;
            chk_en = 1'b0;
            n_flush = flush_rem - 1;
        end else if (stall_rem > 0) begin
            {e_pc, e_en, e_fl, e_bub} = 4'b0001;
            n_stall = stall_rem - 1;
        end else if (ex_h) begin
            {e_pc, e_en, e_fl, e_bub} = 4'b0001;
            n_stall = 1;
        end else if (mem_h) begin
            {e_pc, e_en, e_fl, e_bub} = 4'b0001;
        end else begin
            {e_pc, e_en, e_fl, e_bub} = 4'b1100;
        end

        check("pc_en", 32'(pc_en), 32'(e_pc));
        if (chk_en) check("ifid_en", 32'(ifid_en), 32'(e_en));
        check("ifid_flush", 32'(ifid_flush), 32'(e_fl));
        check("idex_bubble", 32'(idex_bubble), 32'(e_bub));
        check("busy", 32'(busy), 32'(e_busy));
`ifdef HAZ_STATS_EN
        check("stall_cnt", stall_cnt, m_stall_cnt);
        check("flush_cnt", flush_cnt, m_flush_cnt);
`else
        check("stall_cnt", stall_cnt, 32'd0);
        check("flush_cnt", flush_cnt, 32'd0);
`endif
        obs_pc_en = pc_en;
        obs_flush = ifid_flush;

        @(posedge clk);
        if (!rst && !ext_stall) begin
            stall_rem = n_stall;
            flush_rem = n_flush;
            if (e_bub && !e_fl) m_stall_cnt = m_stall_cnt + 32'd1;
            if (e_fl)           m_flush_cnt = m_flush_cnt + 32'd1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    int          cnt;
    logic        prev_ext, prev_br;
    logic [31:0] base;

    initial begin
        rst = 1'b1;
        idle();
        @(negedge clk);

        // Reset for three cycles, then normal flow.
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        check("post_reset_pc_en", 32'(obs_pc_en), 32'd1);

        // EX producer: two stall cycles, then run.
        cnt = 0;
        set_in(5, 0, 1, 0, 5, 1, 0, 0, 0, 0); cyc(); cnt += int'(!obs_pc_en);
        set_in(5, 0, 1, 0, 0, 0, 5, 1, 0, 0); cyc(); cnt += int'(!obs_pc_en);
        set_in(5, 0, 1, 0, 0, 0, 0, 0, 0, 0); cyc(); cnt += int'(!obs_pc_en);
        check("ex_stall_len", 32'(cnt), 32'd2);
`ifdef HAZ_STATS_EN
        check("ex_stall_cnt", stall_cnt, 32'd2);
`endif

        // MEM producer only: one stall cycle, busy stays low.
        cnt = 0;
        set_in(0, 9, 0, 1, 0, 0, 9, 1, 0, 0); cyc(); cnt += int'(!obs_pc_en);
        set_in(0, 9, 0, 1, 0, 0, 0, 0, 0, 0); cyc(); cnt += int'(!obs_pc_en);
        check("mem_stall_len", 32'(cnt), 32'd1);

        // Branch taken during a stall cancels it and flushes FC cycles.
        cnt = 0;
        base = flush_cnt;
        set_in(3, 0, 1, 0, 3, 1, 0, 0, 0, 0); cyc();
        set_in(3, 0, 1, 0, 0, 0, 3, 1, 1, 0); cyc(); cnt += int'(obs_flush);
        idle();                               cyc(); cnt += int'(obs_flush);
        cyc();                                       cnt += int'(obs_flush);
        check("br_flush_len", 32'(cnt), 32'(FC));
`ifdef HAZ_STATS_EN
        check("br_flush_cnt", flush_cnt - base, 32'(FC));
`endif

        // Freeze for four cycles mid-stall, then the last stall cycle.
        set_in(4, 0, 1, 0, 4, 1, 0, 0, 0, 0); cyc();
        set_in(4, 0, 1, 0, 0, 0, 4, 1, 0, 1); repeat (4) cyc();
        set_in(4, 0, 1, 0, 0, 0, 4, 1, 0, 0); cyc();
        check("freeze_resume_stall", 32'(obs_pc_en), 32'd0);
        idle(); cyc();

        // No hazard when the source is unused or EX does not write.
        set_in(7, 0, 0, 0, 7, 1, 0, 0, 0, 0); cyc();
        set_in(7, 0, 1, 0, 7, 0, 0, 0, 0, 0); cyc();

        // Reset asserted mid-flush aborts immediately.
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); cyc();
        idle(); rst = 1'b1; cyc();
        rst = 1'b0; cyc();

        // Randomized traffic with small index space to provoke hits.
        prev_ext = 1'b0;
        prev_br  = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            id_rs     = AW'($urandom_range(0, 3));
            id_rt     = AW'($urandom_range(0, 3));
            id_use_rs = 1'($urandom);
            id_use_rt = 1'($urandom);
            ex_rd     = AW'($urandom_range(0, 3));
            ex_wr     = 1'($urandom);
            mem_rd    = AW'($urandom_range(0, 3));
            mem_wr    = 1'($urandom);
            ext_stall = ($urandom_range(0, 9) == 0);
            br_taken  = prev_ext ? prev_br : ($urandom_range(0, 11) == 0);
            rst       = ($urandom_range(0, 249) == 0);
            prev_ext  = ext_stall;
            prev_br   = br_taken;
            cyc();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
